// File: rtl/keypad_entry_buffer.sv
// ---------------------------------------------------------------------------
// keypad_entry_buffer
//
// Sits behind the 4x4 keypad scan driver. The driver toggles cambio_digito
// once per scan in which a key row is active, so a held key produces a
// stream of events. This block accepts only the first event of a press,
// then ignores further events until the line has been quiet for
// RELEASE_CYCLES clocks. Accepted keys build a BCD entry: digits shift in
// at the least significant nibble, with backspace, clear and enter keys.
//
// Parameters:
//   NUM_DIGITS      number of BCD digits in the entry buffer (1..15)
//   RELEASE_CYCLES  quiet clocks before a key counts as released (2..255)
//
// Optional build macro:
//   AUTO_COMMIT_EN  when defined, the digit that fills the buffer also
//                   commits the entry, exactly as if enter had been pressed
//
// Ports:
//   clk            system clock (same clock as the keypad driver)
//   rst            asynchronous, active-high reset
//   digito         key code: 0-9 digit, 0xA enter, 0xB backspace,
//                  0xC clear, anything else ignored
//   cambio_digito  key-event toggle from the driver
//   entry_bcd      live entry, digit 0 in bits [3:0]
//   entry_count    number of digits currently entered
//   value_bcd      last committed value
//   value_valid    one-cycle pulse when value_bcd is updated
//   overflow       sticky flag: digit pressed while the buffer was full
//   busy           high while a key is considered held
// ---------------------------------------------------------------------------
module keypad_entry_buffer #(
  parameter int NUM_DIGITS     = 4,
  parameter int RELEASE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              digito,
  input  logic                    cambio_digito,
  output logic [4*NUM_DIGITS-1:0] entry_bcd,
  output logic [3:0]              entry_count,
  output logic [4*NUM_DIGITS-1:0] value_bcd,
  output logic                    value_valid,
  output logic                    overflow,
  output logic                    busy
);

  localparam int              W        = 4 * NUM_DIGITS;
  localparam logic [3:0]      FULL     = 4'(NUM_DIGITS);
  localparam logic [7:0]      REL_LAST = 8'(RELEASE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t        state, state_nxt;
  logic          tog_q;
  logic [7:0]    quiet, quiet_nxt;
  logic [W-1:0]  entry_nxt, value_nxt;
  logic [3:0]    count_nxt;
  logic          valid_nxt, ovf_nxt;
  logic          key_event;
  logic [W-1:0]  shifted_in;

  // A key event is any difference between the toggle line and its last
  // sampled value, so it is seen at the very first edge after it changes.
  assign key_event  = (cambio_digito != tog_q);

  // Entry with the incoming digit appended at the low nibble; the top
  // nibble falls off, which only matters when the buffer is already full
  // and that case never uses this value.
  assign shifted_in = (entry_bcd << 4) | W'(digito[3:0]);

  assign busy = (state == HOLD);

  // Next-state and key-action logic. Actions happen only on the first
  // event seen from IDLE; while in HOLD, events only restart the quiet
  // counter so a held key (or a bouncing code) is never applied twice.
  always_comb begin
    state_nxt = state;
    quiet_nxt = quiet;
    entry_nxt = entry_bcd;
    count_nxt = entry_count;
    value_nxt = value_bcd;
    valid_nxt = 1'b0;
    ovf_nxt   = overflow;

    case (state)
      IDLE: begin
        if (key_event) begin
          quiet_nxt = 8'd0;
          state_nxt = HOLD;
          case (digito)
            5'h0A: begin
              if (entry_count != 4'd0) begin
                value_nxt = entry_bcd;
                valid_nxt = 1'b1;
                entry_nxt = '0;
                count_nxt = 4'd0;
                ovf_nxt   = 1'b0;
              end
            end
            5'h0B: begin
              if (entry_count != 4'd0) begin
                entry_nxt = entry_bcd >> 4;
                count_nxt = entry_count - 4'd1;
              end
            end
            5'h0C: begin
              entry_nxt = '0;
              count_nxt = 4'd0;
              ovf_nxt   = 1'b0;
            end
            default: begin
              if (digito < 5'd10) begin
                if (entry_count < FULL) begin
`ifdef AUTO_COMMIT_EN
                  if (entry_count == FULL - 4'd1) begin
                    value_nxt = shifted_in;
                    valid_nxt = 1'b1;
                    entry_nxt = '0;
                    count_nxt = 4'd0;
                  end else begin
                    entry_nxt = shifted_in;
                    count_nxt = entry_count + 4'd1;
                  end
`else
                  entry_nxt = shifted_in;
                  count_nxt = entry_count + 4'd1;
`endif
                end else begin
                  ovf_nxt = 1'b1;
                end
              end
            end
          endcase
        end
      end

      HOLD: begin
        if (key_event) begin
          quiet_nxt = 8'd0;
        end else if (quiet == REL_LAST) begin
          quiet_nxt = 8'd0;
          state_nxt = IDLE;
        end else begin
          quiet_nxt = quiet + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        quiet_nxt = 8'd0;
      end
    endcase
  end

  // State, toggle sampler and all outputs are registered; reset returns
  // everything to zero immediately, dropping any half-seen event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tog_q       <= 1'b0;
      quiet       <= 8'd0;
      entry_bcd   <= '0;
      entry_count <= 4'd0;
      value_bcd   <= '0;
      value_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      tog_q       <= cambio_digito;
      quiet       <= quiet_nxt;
      entry_bcd   <= entry_nxt;
      entry_count <= count_nxt;
      value_bcd   <= value_nxt;
      value_valid <= valid_nxt;
      overflow    <= ovf_nxt;
    end
  end

endmodule
